// File: rtl/ntt_bf_sched_if.sv
// ntt_bf_sched_if: controller / memory-side bundle of the butterfly scheduler.
// master = top-level controller side, slave = scheduler side.
interface ntt_bf_sched_if #(
    parameter int LOG_N = 8
);
    logic             start;
    logic             mode;
    logic             busy;
    logic             done;
    logic             sel;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_u;
    logic [LOG_N-1:0] rd_addr_v;
    logic [LOG_N-1:0] tw_addr;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_u;
    logic [LOG_N-1:0] wr_addr_v;

    modport master (
        output start, mode,
        input  busy, done, sel, rd_en,
        input  rd_addr_u, rd_addr_v, tw_addr,
        input  wr_en, wr_addr_u, wr_addr_v
    );

    modport slave (
        input  start, mode,
        output busy, done, sel, rd_en,
        output rd_addr_u, rd_addr_v, tw_addr,
        output wr_en, wr_addr_u, wr_addr_v
    );
endinterface

// File: rtl/ntt_bf_sched.sv
// ntt_bf_sched: issue-side scheduler for the radix-2 butterfly PE.
// FSM runs one cycle ahead of the registered read-side outputs.
module ntt_bf_sched #(
    parameter int LOG_N  = 8,
    parameter int PE_LAT = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    ntt_bf_sched_if.slave bus
);
    localparam int N  = 1 << LOG_N;
    localparam int H  = N / 2;
    localparam int D  = RD_LAT + PE_LAT;
    localparam int BW = LOG_N - 1;
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    localparam int CW = $clog2(D) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [BW-1:0]    b_q, b_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG_N-1:0] rd_u_q, rd_u_d;
    logic [LOG_N-1:0] rd_v_q, rd_v_d;
    logic [LOG_N-1:0] tw_q, tw_d;

    logic             dl_v_q  [D];
    logic             dl_v_d  [D];
    logic [LOG_N-1:0] dl_au_q [D];
    logic [LOG_N-1:0] dl_au_d [D];
    logic [LOG_N-1:0] dl_av_q [D];
    logic [LOG_N-1:0] dl_av_d [D];

    logic [SW-1:0]    lg;
    logic [LOG_N-1:0] one, bx, jx, kx, ux, vx, twx;

    // Stage/butterfly sequencing with a fixed drain between stages.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    mode_d  = bus.mode;
                    b_d     = '0;
                    s_d     = '0;
                end
            end
            S_ISSUE: begin
                b_d = b_q + 1'b1;
                if (b_q == BW'(H - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(D - 1)) begin
                    if (s_q == SW'(LOG_N - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        s_d     = s_q + 1'b1;
                        b_d     = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Split butterfly index into group j and offset k for this stage.
    always_comb begin
        one = LOG_N'(1);
        bx  = {1'b0, b_q};
        lg  = mode_q ? s_q : (SW'(LOG_N - 1) - s_q);
        kx  = bx & ((one << lg) - one);
        jx  = bx >> lg;
        ux  = ((jx << lg) << 1) | kx;
        vx  = ux | (one << lg);
        if (mode_q) begin
            twx = ({LOG_N{1'b1}} >> s_q) - jx;
        end else begin
            twx = (one << s_q) + jx;
        end
    end

    // Registered read-side outputs; addresses hold when idle.
    always_comb begin
        busy_d  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done_d  = (state_q == S_FIN);
        rd_en_d = (state_q == S_ISSUE);
        rd_u_d  = rd_en_d ? ux : rd_u_q;
        rd_v_d  = rd_en_d ? vx : rd_v_q;
        tw_d    = rd_en_d ? twx : tw_q;
    end

    // Write-back delay line tracking each issue through RAM and PE.
    always_comb begin
        dl_v_d[0]  = rd_en_q;
        dl_au_d[0] = rd_u_q;
        dl_av_d[0] = rd_v_q;
        for (int i = 1; i < D; i++) begin
            dl_v_d[i]  = dl_v_q[i-1];
            dl_au_d[i] = dl_au_q[i-1];
            dl_av_d[i] = dl_av_q[i-1];
        end
    end

    // State update; reset also flushes in-flight write slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_u_q  <= '0;
            rd_v_q  <= '0;
            tw_q    <= '0;
            for (int i = 0; i < D; i++) begin
                dl_v_q[i]  <= 1'b0;
                dl_au_q[i] <= '0;
                dl_av_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_u_q  <= rd_u_d;
            rd_v_q  <= rd_v_d;
            tw_q    <= tw_d;
            for (int i = 0; i < D; i++) begin
                dl_v_q[i]  <= dl_v_d[i];
                dl_au_q[i] <= dl_au_d[i];
                dl_av_q[i] <= dl_av_d[i];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sel       = mode_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_u = rd_u_q;
    assign bus.rd_addr_v = rd_v_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = dl_v_q[D-1];
    assign bus.wr_addr_u = dl_au_q[D-1];
    assign bus.wr_addr_v = dl_av_q[D-1];
endmodule

// File: tb/tb_ntt_bf_sched.sv
// tb_ntt_bf_sched: random NTT/INTT runs on LOG_N=8 and LOG_N=4 schedulers
// against a loop-nest model of the issue/write schedule.
module tb_ntt_bf_sched;
    logic clk;
    logic rst;
    logic start_r;
    logic mode_r;
    logic use8;
    int   n_chk;
    int   n_bad;

    int iu [int];
    int iv [int];
    int it [int];

    ntt_bf_sched_if #(.LOG_N(8)) bus8 ();
    ntt_bf_sched_if #(.LOG_N(4)) bus4 ();

    assign bus8.start = use8 & start_r;
    assign bus4.start = ~use8 & start_r;
    assign bus8.mode  = mode_r;
    assign bus4.mode  = mode_r;

    ntt_bf_sched #(.LOG_N(8), .PE_LAT(6), .RD_LAT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    ntt_bf_sched #(.LOG_N(4), .PE_LAT(6), .RD_LAT(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    logic [4:0]  o_ctl;
    logic [23:0] o_rd;
    logic [15:0] o_wr;

    // Observe whichever instance is under test.
    always_comb begin
        if (use8) begin
            o_ctl = {bus8.busy, bus8.done, bus8.sel,
                     bus8.rd_en, bus8.wr_en};
            o_rd  = {bus8.rd_addr_u, bus8.rd_addr_v, bus8.tw_addr};
            o_wr  = {bus8.wr_addr_u, bus8.wr_addr_v};
        end else begin
            o_ctl = {bus4.busy, bus4.done, bus4.sel,
                     bus4.rd_en, bus4.wr_en};
            o_rd  = {4'b0, bus4.rd_addr_u, 4'b0, bus4.rd_addr_v,
                     4'b0, bus4.tw_addr};
            o_wr  = {4'b0, bus4.wr_addr_u, 4'b0, bus4.wr_addr_v};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transform: m = mode, inj = cycle of an extra start pulse,
    // rst_at = cycle reset is raised (-1 for none).
    task automatic run(input int L, input bit m, input int inj,
                       input int rst_at);
        int n, h, d, len, c0, lastw, end_c;
        bit z, e_rd, e_wr, e_busy, e_done, e_sel;
        logic [23:0] e_r;
        logic [15:0] e_w;
        n = 1 << L;
        h = n / 2;
        d = 7;
        iu.delete();
        iv.delete();
        it.delete();
        for (int s = 0; s < L; s++) begin
            len = m ? (1 << s) : (n >> (s + 1));
            for (int j = 0; j < h / len; j++) begin
                for (int k = 0; k < len; k++) begin
                    c0 = 1 + s * (h + d) + j * len + k;
                    iu[c0] = j * 2 * len + k;
                    iv[c0] = j * 2 * len + k + len;
                    it[c0] = m ? ((n >> s) - 1 - j) : ((1 << s) + j);
                end
            end
        end
        lastw = 1 + (L - 1) * (h + d) + h - 1 + d;
        end_c = (rst_at >= 0) ? rst_at + 20 : lastw + 2;
        use8  = (L == 8);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        start_r = 1'b1;
        mode_r  = m;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        mode_r  = 1'($urandom);
        for (int c = 0; c <= end_c; c++) begin
            z      = (rst_at >= 0) && (c > rst_at);
            e_rd   = !z && iu.exists(c);
            e_wr   = !z && iu.exists(c - d);
            e_busy = !z && (c >= 1) && (c <= lastw);
            e_done = !z && (c == lastw + 1);
            e_sel  = !z && m;
            chk($sformatf("ctl L%0d m%0d c%0d", L, m, c),
                64'(o_ctl), 64'({e_busy, e_done, e_sel, e_rd, e_wr}));
            if (e_rd) begin
                e_r = {8'(iu[c]), 8'(iv[c]), 8'(it[c])};
                chk($sformatf("rd L%0d m%0d c%0d", L, m, c),
                    64'(o_rd), 64'(e_r));
            end
            if (e_wr) begin
                e_w = {8'(iu[c-d]), 8'(iv[c-d])};
                chk($sformatf("wr L%0d m%0d c%0d", L, m, c),
                    64'(o_wr), 64'(e_w));
            end
            if (z) begin
                chk($sformatf("rst_rd c%0d", c), 64'(o_rd), 64'(0));
                chk($sformatf("rst_wr c%0d", c), 64'(o_wr), 64'(0));
            end
            start_r = (c == inj);
            rst     = (c == rst_at);
            @(posedge clk);
            #1;
        end
        start_r = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start_r = 1'b0;
        mode_r  = 1'b0;
        use8    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset8_ctl", 64'(o_ctl), 64'(0));
        chk("reset8_rd", 64'(o_rd), 64'(0));
        chk("reset8_wr", 64'(o_wr), 64'(0));
        use8 = 1'b0;
        #1;
        chk("reset4_ctl", 64'(o_ctl), 64'(0));
        chk("reset4_rd", 64'(o_rd), 64'(0));
        chk("reset4_wr", 64'(o_wr), 64'(0));
        rst = 1'b0;
        run(8, 1'b0, 300, -1);
        run(8, 1'b1, int'($urandom_range(1, 1080)), -1);
        run(8, 1'($urandom), int'($urandom_range(1, 499)), 500);
        run(8, 1'($urandom), int'($urandom_range(1, 1080)), -1);
        run(4, 1'b0, -1, -1);
        run(4, 1'b1, int'($urandom_range(1, 60)), -1);
        run(4, 1'($urandom), int'($urandom_range(1, 29)), 30);
        run(4, 1'($urandom), 60, -1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
